// File: rtl/osd_dem_regresp.sv
// osd_dem_regresp: debug-ring register-access responder.
// Serves 16-bit register reads/writes against a small local register file.
module osd_dem_regresp #(
    parameter logic [15:0] VENDOR   = 16'h0001,
    parameter logic [15:0] TYPE     = 16'h0000,
    parameter logic [15:0] VERSION  = 16'h0000,
    parameter int          NUM_USER = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [15:0]             id,
    input  logic [15:0]             debug_in_data,
    input  logic                    debug_in_first,
    input  logic                    debug_in_last,
    input  logic                    debug_in_valid,
    output logic                    debug_in_ready,
    output logic [15:0]             debug_out_data,
    output logic                    debug_out_first,
    output logic                    debug_out_last,
    output logic                    debug_out_valid,
    input  logic                    debug_out_ready,
    output logic [15:0]             event_dest,
    output logic [15:0]             cs,
    output logic [16*NUM_USER-1:0]  user_regs
);

    typedef enum logic [3:0] {
        RX_DEST, RX_SRC, RX_FLAGS, RX_ADDR, RX_DATA,
        DRAIN, TX_DEST, TX_SRC, TX_FLAGS, TX_DATA
    } state_e;

    localparam logic [15:0] RD_OK  = 16'h2000;
    localparam logic [15:0] RD_ERR = 16'h3000;
    localparam logic [15:0] WR_OK  = 16'h3400;
    localparam logic [15:0] WR_ERR = 16'h3800;

    state_e                  state_q, state_d;
    logic                    match_q, match_d;
    logic                    cls_wr_q, cls_wr_d;
    logic                    sub_ok_q, sub_ok_d;
    logic                    has_data_q, has_data_d;
    logic [15:0]             src_q, src_d;
    logic [15:0]             addr_q, addr_d;
    logic [15:0]             rdata_q, rdata_d;
    logic [15:0]             resp_q, resp_d;
    logic [15:0]             event_dest_q, event_dest_d;
    logic [15:0]             cs_q, cs_d;
    logic [16*NUM_USER-1:0]  user_regs_q, user_regs_d;

    logic                    accept;
    logic [15:0]             dec_addr;
    logic [15:0]             uoff;
    logic                    user_hit;
    logic                    rd_hit;
    logic                    wr_hit;
    logic [15:0]             rd_val;

    assign debug_in_ready = state_q inside {RX_DEST, RX_SRC, RX_FLAGS,
                                            RX_ADDR, RX_DATA, DRAIN};
    assign accept     = debug_in_valid & debug_in_ready;
    assign event_dest = event_dest_q;
    assign cs         = cs_q;
    assign user_regs  = user_regs_q;

    // Address decode: live addr word during RX_ADDR, latched addr afterwards
    always_comb begin
        dec_addr = (state_q == RX_ADDR) ? debug_in_data : addr_q;
        uoff     = dec_addr - 16'h0200;
        user_hit = uoff < 16'(NUM_USER);
        rd_val   = 16'h0000;
        rd_hit   = 1'b1;
        wr_hit   = 1'b0;
        case (dec_addr)
            16'h0000: rd_val = VENDOR;
            16'h0001: rd_val = TYPE;
            16'h0002: rd_val = VERSION;
            16'h0003: begin
                rd_val = event_dest_q;
                wr_hit = 1'b1;
            end
            16'h0004: begin
                rd_val = cs_q;
                wr_hit = 1'b1;
            end
            default: begin
                if (user_hit) begin
                    wr_hit = 1'b1;
                    for (int i = 0; i < NUM_USER; i++) begin
                        if (uoff == 16'(i)) rd_val = user_regs_q[16*i +: 16];
                    end
                end else begin
                    rd_hit = 1'b0;
                end
            end
        endcase
    end

    // Next-state, capture, register write and response output logic
    always_comb begin
        state_d         = state_q;
        match_d         = match_q;
        cls_wr_d        = cls_wr_q;
        sub_ok_d        = sub_ok_q;
        has_data_d      = has_data_q;
        src_d           = src_q;
        addr_d          = addr_q;
        rdata_d         = rdata_q;
        resp_d          = resp_q;
        event_dest_d    = event_dest_q;
        cs_d            = cs_q;
        user_regs_d     = user_regs_q;
        debug_out_valid = 1'b0;
        debug_out_data  = 16'h0000;
        debug_out_first = 1'b0;
        debug_out_last  = 1'b0;

        case (state_q)
            RX_DEST: begin
                if (accept && debug_in_first && !debug_in_last) begin
                    match_d = (debug_in_data == id);
                    state_d = RX_SRC;
                end
            end
            RX_SRC: begin
                if (accept) begin
                    if (debug_in_last) begin
                        state_d = RX_DEST;
                    end else begin
                        src_d   = debug_in_data;
                        state_d = RX_FLAGS;
                    end
                end
            end
            RX_FLAGS: begin
                if (accept) begin
                    if (debug_in_last) begin
                        state_d = RX_DEST;
                    end else begin
                        cls_wr_d   = debug_in_data[13:10] >= 4'd4;
                        sub_ok_d   = (debug_in_data[15:14] == 2'd0) &&
                                     ((debug_in_data[13:10] == 4'd0) ||
                                      (debug_in_data[13:10] == 4'd4));
                        has_data_d = 1'b0;
                        state_d    = RX_ADDR;
                    end
                end
            end
            RX_ADDR: begin
                if (accept) begin
                    addr_d  = debug_in_data;
                    rdata_d = rd_val;
                    if (cls_wr_q) begin
                        state_d = debug_in_last ? RX_DEST : RX_DATA;
                    end else if (debug_in_last) begin
                        has_data_d = sub_ok_q && rd_hit;
                        resp_d     = (sub_ok_q && rd_hit) ? RD_OK : RD_ERR;
                        state_d    = match_q ? TX_DEST : RX_DEST;
                    end else begin
                        has_data_d = 1'b0;
                        resp_d     = RD_ERR;
                        state_d    = DRAIN;
                    end
                end
            end
            RX_DATA: begin
                if (accept) begin
                    if (debug_in_last) begin
                        resp_d  = (sub_ok_q && wr_hit) ? WR_OK : WR_ERR;
                        state_d = match_q ? TX_DEST : RX_DEST;
                        if (match_q && sub_ok_q && wr_hit) begin
                            case (addr_q)
                                16'h0003: event_dest_d = debug_in_data;
                                16'h0004: cs_d = debug_in_data;
                                default: begin
                                    for (int i = 0; i < NUM_USER; i++) begin
                                        if (uoff == 16'(i))
                                            user_regs_d[16*i +: 16] = debug_in_data;
                                    end
                                end
                            endcase
                        end
                    end else begin
                        resp_d  = WR_ERR;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (accept && debug_in_last) begin
                    state_d = match_q ? TX_DEST : RX_DEST;
                end
            end
            TX_DEST: begin
                debug_out_valid = 1'b1;
                debug_out_first = 1'b1;
                debug_out_data  = src_q;
                if (debug_out_ready) state_d = TX_SRC;
            end
            TX_SRC: begin
                debug_out_valid = 1'b1;
                debug_out_data  = id;
                if (debug_out_ready) state_d = TX_FLAGS;
            end
            TX_FLAGS: begin
                debug_out_valid = 1'b1;
                debug_out_data  = resp_q;
                debug_out_last  = !has_data_q;
                if (debug_out_ready) state_d = has_data_q ? TX_DATA : RX_DEST;
            end
            TX_DATA: begin
                debug_out_valid = 1'b1;
                debug_out_data  = rdata_q;
                debug_out_last  = 1'b1;
                if (debug_out_ready) state_d = RX_DEST;
            end
            default: state_d = RX_DEST;
        endcase
    end

    // State and register file flops with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= RX_DEST;
            match_q      <= 1'b0;
            cls_wr_q     <= 1'b0;
            sub_ok_q     <= 1'b0;
            has_data_q   <= 1'b0;
            src_q        <= 16'h0000;
            addr_q       <= 16'h0000;
            rdata_q      <= 16'h0000;
            resp_q       <= 16'h0000;
            event_dest_q <= 16'h0000;
            cs_q         <= 16'h0000;
            user_regs_q  <= '0;
        end else begin
            state_q      <= state_d;
            match_q      <= match_d;
            cls_wr_q     <= cls_wr_d;
            sub_ok_q     <= sub_ok_d;
            has_data_q   <= has_data_d;
            src_q        <= src_d;
            addr_q       <= addr_d;
            rdata_q      <= rdata_d;
            resp_q       <= resp_d;
            event_dest_q <= event_dest_d;
            cs_q         <= cs_d;
            user_regs_q  <= user_regs_d;
        end
    end

endmodule

// File: tb/tb_osd_dem_regresp.sv
// tb_osd_dem_regresp: vector table plus hand sequences for osd_dem_regresp.
// Expected response words are queued at stimulus time and popped by a monitor.
module tb_osd_dem_regresp;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] id = 16'h0002;
    logic [15:0] in_data = '0;
    logic        in_first = 1'b0;
    logic        in_last = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_first;
    logic        out_last;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] event_dest;
    logic [15:0] cs;
    logic [63:0] user_regs;

    always #5 clk = ~clk;

    osd_dem_regresp #(.NUM_USER(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .id              (id),
        .debug_in_data   (in_data),
        .debug_in_first  (in_first),
        .debug_in_last   (in_last),
        .debug_in_valid  (in_valid),
        .debug_in_ready  (in_ready),
        .debug_out_data  (out_data),
        .debug_out_first (out_first),
        .debug_out_last  (out_last),
        .debug_out_valid (out_valid),
        .debug_out_ready (out_ready),
        .event_dest      (event_dest),
        .cs              (cs),
        .user_regs       (user_regs)
    );

    int n_chk = 0;
    int n_pass = 0;
    logic [17:0] exp_q[$];

    typedef struct {
        logic [15:0] dest;
        logic [15:0] src;
        logic [15:0] flags;
        logic [15:0] addr;
        logic [15:0] wdata;
        bit          wr;
        bit          resp;
        logic [15:0] eflags;
        logic [15:0] edata;
        bit          hd;
    } vec_t;

    localparam int NV = 20;
    vec_t vt[NV];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_word: got f=%b l=%b d=%h expected none",
                         out_first, out_last, out_data);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                chk("resp_word", {46'b0, out_first, out_last, out_data},
                    {46'b0, e});
            end
        end
    end

    task automatic send_word(input logic [15:0] d, input logic f,
                             input logic l);
        int b;
        logic acc;
        in_data  = d;
        in_first = f;
        in_last  = l;
        in_valid = 1'b1;
        b = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            b++;
        end while (!acc && b < 40);
        if (!acc) begin
            n_chk++;
            $display("FAIL send_timeout: got ready=0 expected ready=1");
        end
    endtask

    task automatic send_pkt(input logic [15:0] dest, input logic [15:0] src,
                            input logic [15:0] flags, input logic [15:0] addr,
                            input logic [15:0] wdata, input bit wr);
        send_word(dest, 1'b1, 1'b0);
        send_word(src, 1'b0, 1'b0);
        send_word(flags, 1'b0, 1'b0);
        send_word(addr, 1'b0, !wr);
        if (wr) send_word(wdata, 1'b0, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic push_resp(input logic [15:0] dest, input logic [15:0] flags,
                             input logic [15:0] data, input bit hd);
        exp_q.push_back({1'b1, 1'b0, dest});
        exp_q.push_back({1'b0, 1'b0, id});
        exp_q.push_back({1'b0, !hd, flags});
        if (hd) exp_q.push_back({1'b0, 1'b1, data});
    endtask

    task automatic wait_idle();
        int b;
        b = 0;
        while ((exp_q.size() != 0 || out_valid) && b < 60) begin
            @(posedge clk);
            #1;
            b++;
        end
        if (b >= 60) begin
            n_chk++;
            $display("FAIL idle_timeout: got %0d pending words expected 0",
                     exp_q.size());
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{16'h0002, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h2000, 16'h0001, 1'b1};
        vt[1]  = '{16'h0002, 16'h0011, 16'h0000, 16'h0001, 16'h0000, 1'b0, 1'b1, 16'h2000, 16'h0000, 1'b1};
        vt[2]  = '{16'h0002, 16'h0012, 16'h0000, 16'h0002, 16'h0000, 1'b0, 1'b1, 16'h2000, 16'h0000, 1'b1};
        vt[3]  = '{16'h0002, 16'h0013, 16'h1000, 16'h0003, 16'hBEEF, 1'b1, 1'b1, 16'h3400, 16'h0000, 1'b0};
        vt[4]  = '{16'h0002, 16'h0014, 16'h0000, 16'h0003, 16'h0000, 1'b0, 1'b1, 16'h2000, 16'hBEEF, 1'b1};
        vt[5]  = '{16'h0002, 16'h0015, 16'h1000, 16'h0000, 16'h1234, 1'b1, 1'b1, 16'h3800, 16'h0000, 1'b0};
        vt[6]  = '{16'h0002, 16'h0016, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h2000, 16'h0001, 1'b1};
        vt[7]  = '{16'h0002, 16'h0017, 16'h0000, 16'h0100, 16'h0000, 1'b0, 1'b1, 16'h3000, 16'h0000, 1'b0};
        vt[8]  = '{16'h0002, 16'h0018, 16'h0400, 16'h0003, 16'h0000, 1'b0, 1'b1, 16'h3000, 16'h0000, 1'b0};
        vt[9]  = '{16'h0002, 16'h0019, 16'h1000, 16'h0004, 16'h0001, 1'b1, 1'b1, 16'h3400, 16'h0000, 1'b0};
        vt[10] = '{16'h0002, 16'h001A, 16'h1000, 16'h0203, 16'hA5A5, 1'b1, 1'b1, 16'h3400, 16'h0000, 1'b0};
        vt[11] = '{16'h0002, 16'h001B, 16'h0000, 16'h0203, 16'h0000, 1'b0, 1'b1, 16'h2000, 16'hA5A5, 1'b1};
        vt[12] = '{16'h0002, 16'h001C, 16'h1000, 16'h0204, 16'h1111, 1'b1, 1'b1, 16'h3800, 16'h0000, 1'b0};
        vt[13] = '{16'h0002, 16'h001D, 16'h0000, 16'h0204, 16'h0000, 1'b0, 1'b1, 16'h3000, 16'h0000, 1'b0};
        vt[14] = '{16'h0002, 16'h001E, 16'h4000, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h3000, 16'h0000, 1'b0};
        vt[15] = '{16'h0002, 16'h001F, 16'h1400, 16'h0003, 16'hDEAD, 1'b1, 1'b1, 16'h3800, 16'h0000, 1'b0};
        vt[16] = '{16'h0007, 16'h0020, 16'h1000, 16'h0003, 16'h5555, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vt[17] = '{16'h0002, 16'h0021, 16'h0000, 16'h0003, 16'h0000, 1'b0, 1'b1, 16'h2000, 16'hBEEF, 1'b1};
        vt[18] = '{16'h0002, 16'h0022, 16'h1000, 16'h0002, 16'h7777, 1'b1, 1'b1, 16'h3800, 16'h0000, 1'b0};
        vt[19] = '{16'h0002, 16'h0023, 16'h0000, 16'h0004, 16'h0000, 1'b0, 1'b1, 16'h2000, 16'h0001, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_event_dest", event_dest, 16'h0000);
        chk("rst_cs", cs, 16'h0000);
        chk("rst_user_regs", user_regs, 64'h0);

        for (int i = 0; i < NV; i++) begin
            if (vt[i].resp)
                push_resp(vt[i].src, vt[i].eflags, vt[i].edata, vt[i].hd);
            send_pkt(vt[i].dest, vt[i].src, vt[i].flags, vt[i].addr,
                     vt[i].wdata, vt[i].wr);
            wait_idle();
            repeat (3) @(posedge clk);
            #1;
        end
        chk("tbl_event_dest", event_dest, 16'hBEEF);
        chk("tbl_cs", cs, 16'h0001);
        chk("tbl_user_regs", user_regs, 64'hA5A5_0000_0000_0000);

        // write visible the cycle after wdata; response valid the same cycle
        push_resp(16'h0024, 16'h3400, 16'h0000, 1'b0);
        send_pkt(16'h0002, 16'h0024, 16'h1000, 16'h0003, 16'h1357, 1'b1);
        chk("wr_event_dest", event_dest, 16'h1357);
        chk("lat_valid_first", {out_valid, out_first}, 2'b11);
        wait_idle();

        // stall the response on its src word for five cycles
        push_resp(16'h0030, 16'h2000, 16'h0001, 1'b1);
        send_pkt(16'h0002, 16'h0030, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_word", {out_valid, out_first, out_last, out_data},
                {1'b1, 1'b0, 1'b0, id});
            chk("stall_in_ready", in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_idle();

        // read missing last on addr: drain two extra words, then READ_ERROR
        push_resp(16'h0040, 16'h3000, 16'h0000, 1'b0);
        send_word(16'h0002, 1'b1, 1'b0);
        send_word(16'h0040, 1'b0, 1'b0);
        send_word(16'h0000, 1'b0, 1'b0);
        send_word(16'h0000, 1'b0, 1'b0);
        send_word(16'hAAAA, 1'b0, 1'b0);
        send_word(16'hBBBB, 1'b0, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_idle();

        // write missing last on wdata: WRITE_ERROR, no write
        push_resp(16'h0041, 16'h3800, 16'h0000, 1'b0);
        send_word(16'h0002, 1'b1, 1'b0);
        send_word(16'h0041, 1'b0, 1'b0);
        send_word(16'h1000, 1'b0, 1'b0);
        send_word(16'h0003, 1'b0, 1'b0);
        send_word(16'h9999, 1'b0, 1'b0);
        send_word(16'h0000, 1'b0, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_idle();
        chk("drain_no_write", event_dest, 16'h1357);

        // early last on flags, then a stray non-first word: no response
        send_word(16'h0002, 1'b1, 1'b0);
        send_word(16'h0050, 1'b0, 1'b0);
        send_word(16'h0000, 1'b0, 1'b1);
        send_word(16'h0002, 1'b0, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        push_resp(16'h0051, 16'h2000, 16'h0001, 1'b1);
        send_pkt(16'h0002, 16'h0051, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        wait_idle();

        // reset in TX_FLAGS of a write response
        exp_q.push_back({1'b1, 1'b0, 16'h0060});
        exp_q.push_back({1'b0, 1'b0, id});
        send_pkt(16'h0002, 16'h0060, 16'h1000, 16'h0200, 16'h00FF, 1'b1);
        chk("user0_written", user_regs[15:0], 16'h00FF);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        chk("rst2_out_valid", out_valid, 1'b0);
        chk("rst2_user_regs", user_regs, 64'h0);
        chk("rst2_event_dest", event_dest, 16'h0000);
        chk("rst2_in_ready", in_ready, 1'b1);
        chk("rst2_pending", exp_q.size(), 0);
        exp_q.delete();
        push_resp(16'h0061, 16'h2000, 16'h0000, 1'b1);
        send_pkt(16'h0002, 16'h0061, 16'h0000, 16'h0200, 16'h0000, 1'b0);
        wait_idle();
        push_resp(16'h0062, 16'h2000, 16'h0001, 1'b1);
        send_pkt(16'h0002, 16'h0062, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        wait_idle();
        repeat (4) @(posedge clk);
        #1;
        chk("final_pending", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
